// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl_if
//  Purpose  : Request/acknowledge bus between the data-memory access
//             controller (master) and a variable-latency data memory (slave).
//  Signals  : mem_req    master->slave  access request, held until ack
//             mem_we     master->slave  1 = write, 0 = read
//             mem_addr   master->slave  word-aligned byte address
//             mem_wdata  master->slave  store data
//             mem_ack    slave->master  completion, 1-cycle pulse
//             mem_rdata  slave->master  read data, valid with mem_ack
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl
//  Purpose  : Sequences EX/MEM loads and stores onto a variable-latency
//             req/ack data memory, stalls the pipeline until the access
//             completes or times out, and extends halfword loads.
//  Ports    : clk, rst_n            clock, asynchronous active-low reset
//             mem_read, mem_write   access request from EX/MEM
//             load_half, load_half_u  halfword load / unsigned halfword
//             addr, wdata           byte address and store data
//             stall                 combinational pipeline hold
//             bus                   memory bus (master modport)
//             load_data, load_valid extended load result and its pulse
//             bus_err               timeout pulse
//             misalign_err          misaligned-access pulse
//  Config   : DMEM_MISALIGN_TRAP_EN  when defined, misaligned accesses are
//             trapped in IDLE (no bus request) and reported on misalign_err;
//             when undefined the low address bits are ignored and
//             misalign_err stays 0.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int TMO_W       = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        mem_read,
    input  wire logic        mem_write,
    input  wire logic        load_half,
    input  wire logic        load_half_u,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    output logic             stall,
    dmem_access_ctrl_if.master bus,
    output logic [31:0]      load_data,
    output logic             load_valid,
    output logic             bus_err,
    output logic             misalign_err
);

    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_half;
    logic              r_half_u;
    logic              r_hi;
    logic [TMO_W-1:0]  r_cnt;

    logic              w_access;
    logic              w_half_req;
    logic              w_trap;
    logic [15:0]       w_half_sel;
    logic [31:0]       w_ext;

    assign w_access   = mem_read | mem_write;
    // A simultaneous read+write is a store, so only a pure read can be a half.
    assign w_half_req = load_half & ~mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_trap = w_half_req ? addr[0] : (addr[1:0] != 2'b00);
`else
    logic w_unused_addr0;
    assign w_unused_addr0 = addr[0];
    assign w_trap         = 1'b0;
`endif

    // Hold the pipeline from the cycle the access is seen until the memory
    // answers; the release cycle (DONE/ERR) lets EX/MEM advance.
    assign stall = rst_n & (((r_state == S_IDLE) & w_access) | (r_state == S_WAIT));

    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign w_half_sel = r_hi ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_ext = bus.mem_rdata;
        if (r_half) begin
            w_ext = r_half_u ? {16'b0, w_half_sel} : {{16{w_half_sel[15]}}, w_half_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'b0;
            r_wdata      <= 32'b0;
            r_half       <= 1'b0;
            r_half_u     <= 1'b0;
            r_hi         <= 1'b0;
            r_cnt        <= '0;
            load_data    <= 32'b0;
            load_valid   <= 1'b0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            load_valid   <= 1'b0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_trap) begin
                            load_data    <= 32'b0;
                            misalign_err <= 1'b1;
                            r_state      <= S_ERR;
                        end else begin
                            r_we     <= mem_write;
                            r_addr   <= {addr[31:2], 2'b00};
                            r_wdata  <= wdata;
                            r_half   <= w_half_req;
                            r_half_u <= load_half_u;
                            r_hi     <= addr[1];
                            r_req    <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (bus.mem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            load_data  <= w_ext;
                            load_valid <= 1'b1;
                        end
                    end else if (r_cnt == c_tmo_last) begin
                        r_req     <= 1'b0;
                        load_data <= 32'b0;
                        bus_err   <= 1'b1;
                        r_state   <= S_ERR;
                    end
                end
                // EX/MEM still shows the finished op here, so nothing is accepted.
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_access_ctrl
//  Purpose  : Self-checking bench for dmem_access_ctrl (TIMEOUT_CYC = 4).
//             A vector table drives single accesses against a small memory
//             model that acks after a per-vector delay; hand-written
//             sequences cover reset, reset mid-access and stray acks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int NO_ACK = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        load_half = 1'b0;
    logic        load_half_u = 1'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] wdata = 32'b0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(
        .TIMEOUT_CYC (4),
        .TMO_W       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .load_half    (load_half),
        .load_half_u  (load_half_u),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .bus          (bus.master),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    // delay: number of WAIT cycles before the ack cycle (0 = ack in first WAIT cycle)
    typedef struct {
        logic        rd;
        logic        wr;
        logic        half;
        logic        half_u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        chk_ld;
        logic [31:0] exp_ld;
        int          exp_stall;
        int          exp_lv;
        int          exp_be;
        int          exp_mis;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          stall_cnt = 0;
        int          lv = 0;
        int          be = 0;
        int          mis = 0;
        int          reqcyc = 0;
        int          tail = 0;
        bit          started = 0;
        bit          released = 0;
        bit          done = 0;
        bit          seen_req = 0;
        logic        we_c = 1'b0;
        logic [31:0] a_c = 32'b0;
        logic [31:0] wd_c = 32'b0;
        @(posedge clk);
        #1;
        mem_read    = v.rd;
        mem_write   = v.wr;
        load_half   = v.half;
        load_half_u = v.half_u;
        addr        = v.addr;
        wdata       = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                stall_cnt++;
                started = 1;
            end
            if (load_valid)   lv++;
            if (bus_err)      be++;
            if (misalign_err) mis++;
            if (bus.mem_req) begin
                if (!seen_req) begin
                    we_c = bus.mem_we;
                    a_c  = bus.mem_addr;
                    wd_c = bus.mem_wdata;
                end
                seen_req = 1;
                bus.mem_ack   = (reqcyc == v.delay);
                bus.mem_rdata = (reqcyc == v.delay) ? v.rdata : 32'h5A5A_0F0F;
                reqcyc++;
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (released) begin
                tail++;
                if (tail >= 2) done = 1;
            end else if (started && !stall) begin
                // Pipeline advances on the release edge: drop the request.
                released  = 1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
        chk($sformatf("v%0d_finished", idx), {31'b0, done}, 32'd1);
        chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.exp_stall);
        chk($sformatf("v%0d_load_valid_pulses", idx), lv, v.exp_lv);
        chk($sformatf("v%0d_bus_err_pulses", idx), be, v.exp_be);
        chk($sformatf("v%0d_misalign_pulses", idx), mis, v.exp_mis);
        chk($sformatf("v%0d_req_seen", idx), {31'b0, seen_req}, {31'b0, v.exp_req});
        if (v.exp_req) begin
            chk($sformatf("v%0d_mem_we", idx), {31'b0, we_c}, {31'b0, v.exp_we});
            chk($sformatf("v%0d_mem_addr", idx), a_c, v.exp_addr);
            if (v.exp_we) chk($sformatf("v%0d_mem_wdata", idx), wd_c, v.wdata);
        end
        if (v.chk_ld) chk($sformatf("v%0d_load_data", idx), load_data, v.exp_ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rd    wr    half  hu    addr          wdata         rdata         dly     chk   exp_ld        st lv be mi req   we    exp_addr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'hCAFE_BABE, 1,      1'b1, 32'hCAFE_BABE, 3, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0,        32'h8001_1234, 0,      1'b1, 32'hFFFF_8001, 2, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0012, 32'h0,        32'h8001_1234, 0,      1'b1, 32'h0000_8001, 2, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'h8001_1234, 0,      1'b1, 32'h0000_1234, 2, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'h1234_ABCD, 0,      1'b1, 32'hFFFF_ABCD, 2, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0,        0,      1'b0, 32'h0,         2, 0, 0, 0, 1'b1, 1'b1, 32'h0000_0020};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h0,        32'hDEAD_BEEF, NO_ACK, 1'b1, 32'h0,         5, 0, 1, 0, 1'b1, 1'b0, 32'h0000_0030};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hAABB_CCDD, 32'h0,        2,      1'b0, 32'h0,         4, 0, 0, 0, 1'b1, 1'b1, 32'h0000_0040};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'h0,        32'h0F0F_0F0F, 3,      1'b1, 32'h0F0F_0F0F, 5, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0050};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0021, 32'h0,        32'h55AA_55AA, 0,      1'b1, 32'h0,         1, 0, 0, 1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,        32'h7FFF_0001, 0,      1'b1, 32'h0,         1, 0, 0, 1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0026, 32'h0102_0304, 32'h0,        0,      1'b1, 32'h0,         1, 0, 0, 1, 1'b0, 1'b0, 32'h0};
`else
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0021, 32'h0,        32'h55AA_55AA, 0,      1'b1, 32'h55AA_55AA, 2, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0020};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,        32'h7FFF_0001, 0,      1'b1, 32'h0000_7FFF, 2, 1, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0026, 32'h0102_0304, 32'h0,        0,      1'b0, 32'h0,         2, 0, 0, 0, 1'b1, 1'b1, 32'h0000_0024};
`endif

        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stall",        {31'b0, stall},        32'd0);
        chk("rst_mem_req",      {31'b0, bus.mem_req},  32'd0);
        chk("rst_mem_we",       {31'b0, bus.mem_we},   32'd0);
        chk("rst_mem_addr",     bus.mem_addr,          32'd0);
        chk("rst_load_data",    load_data,             32'd0);
        chk("rst_load_valid",   {31'b0, load_valid},   32'd0);
        chk("rst_bus_err",      {31'b0, bus_err},      32'd0);
        chk("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted while the controller waits on the memory
        @(posedge clk);
        #1;
        mem_read  = 1'b1;
        load_half = 1'b0;
        addr      = 32'h0000_0060;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midrst_req_before",   {31'b0, bus.mem_req}, 32'd1);
        chk("midrst_stall_before", {31'b0, stall},       32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_after",   {31'b0, bus.mem_req}, 32'd0);
        chk("midrst_stall_after", {31'b0, stall},       32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_idle_stall", {31'b0, stall}, 32'd0);
        run_vec(vecs[0], 100);

        // Ack outside WAIT must be ignored
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_ack_stall",      {31'b0, stall},       32'd0);
        chk("stray_ack_req",        {31'b0, bus.mem_req}, 32'd0);
        chk("stray_ack_load_valid", {31'b0, load_valid},  32'd0);
        @(negedge clk);
        chk("stray_ack_load_valid2", {31'b0, load_valid}, 32'd0);
        chk("stray_ack_load_data",   load_data,           32'hCAFE_BABE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
